// File: rtl/demorgan_sweep_ctrl.sv
// Sweep sequencer and self-checker for the De Morgan gate datapath: walks every
// input vector in ascending order, waits SETTLE cycles, then checks NAND/NOR outputs.
module demorgan_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_nand,
    input  logic            dut_nor,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_seen
);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    localparam logic [7:0]      SETTLE_C = 8'(SETTLE);
    localparam logic [N_IN-1:0] VEC_MAX  = '1;
    localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(1) << N_IN;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fvec_q, fvec_d;
    logic            fseen_q, fseen_d;
    logic            pass_q, pass_d;
    logic            mismatch;

    // Expected values span all N_IN bits: N-input NAND and NOR.
    assign mismatch = (dut_nand != ~(&vec_q)) | (dut_nor != ~(|vec_q));

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fvec_d  = fvec_q;
        fseen_d = fseen_q;
        pass_d  = pass_q;

        if (abort && state_q != IDLE) begin
            // Abort keeps the partial error record for post-mortem inspection.
            state_d = IDLE;
            vec_d   = '0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = WAIT;
                        vec_d   = '0;
                        cnt_d   = SETTLE_C;
                        err_d   = '0;
                        fvec_d  = '0;
                        fseen_d = 1'b0;
                        pass_d  = 1'b0;
                    end
                end
                WAIT: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + (N_IN+1)'(1);
                        end
                        if (!fseen_q) begin
                            fvec_d  = vec_q;
                            fseen_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_MAX) begin
                        state_d = DONE;
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = SETTLE_C;
                        state_d = WAIT;
                    end
                end
                DONE: begin
                    pass_d  = (err_q == '0);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fvec_q  <= '0;
            fseen_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            fseen_q <= fseen_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_out   = vec_q;
    assign busy      = (state_q == WAIT) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fvec_q;
    assign fail_seen = fseen_q;

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Bench for demorgan_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) checked every
// cycle against a sweep-time model, with directed scenarios followed by random stimulus.
module tb_demorgan_sweep_ctrl;

    localparam int N  = 2;
    localparam int NV = 1 << N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    int   mode = 0;

    logic [N-1:0] vec_o [2];
    logic         nand_i[2];
    logic         nor_i [2];
    logic         busy_o[2];
    logic         done_o[2];
    logic         pass_o[2];
    logic [N:0]   err_o [2];
    logic [N-1:0] fvec_o[2];
    logic         fseen_o[2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_at[2];

    // Model state: active sweep flag and cycle index t since the start edge.
    int P[2] = '{2, 4};
    int m_act[2], m_t[2], m_err[2], m_fvec[2], m_fseen[2], m_pass[2], m_vec[2];

    always #5 clk = ~clk;

    // Gate model: mode 0 correct, 1 NOR stuck at 0, 2 NAND inverted, 3 NAND wrong at vector 2.
    function automatic logic [1:0] gate(int m, int v);
        logic nd, nr;
        nd = (v != NV - 1);
        nr = (v == 0);
        case (m)
            1: nr = 1'b0;
            2: nd = ~nd;
            3: if (v == 2) nd = ~nd;
            default: ;
        endcase
        return {nd, nr};
    endfunction

    assign {nand_i[0], nor_i[0]} = gate(mode, int'(vec_o[0]));
    assign {nand_i[1], nor_i[1]} = gate(mode, int'(vec_o[1]));

    demorgan_sweep_ctrl #(.N_IN(N), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .vec_out(vec_o[0]), .dut_nand(nand_i[0]), .dut_nor(nor_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_count(err_o[0]), .fail_vec(fvec_o[0]), .fail_seen(fseen_o[0])
    );

    demorgan_sweep_ctrl #(.N_IN(N), .SETTLE(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .vec_out(vec_o[1]), .dut_nand(nand_i[1]), .dut_nor(nor_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_count(err_o[1]), .fail_vec(fvec_o[1]), .fail_seen(fseen_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_t[i] = 0; m_err[i] = 0; m_fvec[i] = 0;
            m_fseen[i] = 0; m_pass[i] = 0; m_vec[i] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            int last;
            last = NV * P[i];
            chk($sformatf("vec%0d", i),   vec_o[i],   m_vec[i]);
            chk($sformatf("busy%0d", i),  busy_o[i],  (m_act[i] != 0 && m_t[i] <= last));
            chk($sformatf("done%0d", i),  done_o[i],  (m_act[i] != 0 && m_t[i] == last + 1));
            chk($sformatf("pass%0d", i),  pass_o[i],  m_pass[i]);
            chk($sformatf("err%0d", i),   err_o[i],   m_err[i]);
            chk($sformatf("fvec%0d", i),  fvec_o[i],  m_fvec[i]);
            chk($sformatf("fseen%0d", i), fseen_o[i], m_fseen[i]);
        end
    endtask

    task automatic advance(input logic st, input logic ab);
        for (int i = 0; i < 2; i++) begin
            if (m_act[i] == 0) begin
                if (st && !ab) begin
                    m_act[i] = 1; m_t[i] = 1; m_vec[i] = 0; m_err[i] = 0;
                    m_fvec[i] = 0; m_fseen[i] = 0; m_pass[i] = 0;
                end
            end else if (ab) begin
                m_act[i] = 0; m_vec[i] = 0; m_pass[i] = 0;
            end else begin
                if (m_t[i] % P[i] == 0) begin
                    int k;
                    logic [1:0] g;
                    k = m_t[i] / P[i] - 1;
                    g = gate(mode, k);
                    if (g[1] != (k != NV - 1) || g[0] != (k == 0)) begin
                        if (m_err[i] < NV) m_err[i]++;
                        if (m_fseen[i] == 0) begin
                            m_fvec[i] = k;
                            m_fseen[i] = 1;
                        end
                    end
                end
                if (m_t[i] == NV * P[i] + 1) begin
                    m_act[i] = 0;
                    m_pass[i] = (m_err[i] == 0);
                end else begin
                    m_t[i]++;
                    m_vec[i] = (m_t[i] - 1) / P[i];
                    if (m_vec[i] > NV - 1) m_vec[i] = NV - 1;
                end
            end
        end
    endtask

    task automatic step(input logic st, input logic ab, input int newmode);
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < 2; i++)
            if (done_o[i] === 1'b1 && done_at[i] < 0) done_at[i] = cyc;
        mode  = newmode;
        start = st;
        abort = ab;
        advance(st, ab);
    endtask

    task automatic zero_check(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_vec"},   vec_o[i],   0);
            chk({tag, "_busy"},  busy_o[i],  0);
            chk({tag, "_done"},  done_o[i],  0);
            chk({tag, "_pass"},  pass_o[i],  0);
            chk({tag, "_err"},   err_o[i],   0);
            chk({tag, "_fvec"},  fvec_o[i],  0);
            chk({tag, "_fseen"}, fseen_o[i], 0);
        end
    endtask

    // Pull reset between edges and check the outputs clear before the next edge.
    task automatic mid_reset();
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #2 rst_n = 1'b0;
        #1 zero_check("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sweep(input int md, input int len);
        step(1'b1, 1'b0, md);
        for (int c = 1; c <= len; c++) step(1'b0, 1'b0, md);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        zero_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal sweep, with a stray start at cycle 5 that must be ignored.
        done_at[0] = -1; done_at[1] = -1;
        cyc = 0;
        step(1'b1, 1'b0, 0);
        for (int c = 1; c <= 20; c++) begin
            cyc = c;
            step(c == 5, 1'b0, 0);
        end
        chk("done_cycle_settle1", done_at[0], 9);
        chk("done_cycle_settle3", done_at[1], 17);
        chk("nominal_pass", pass_o[0], 1);

        sweep(1, 20);
        chk("nor_stuck_err", err_o[0], 1);
        chk("nor_stuck_fvec", fvec_o[0], 0);
        chk("nor_stuck_fseen", fseen_o[0], 1);
        chk("nor_stuck_pass", pass_o[0], 0);

        sweep(2, 20);
        chk("nand_inv_err", err_o[0], 4);
        chk("nand_inv_err_s3", err_o[1], 4);
        chk("nand_inv_fvec", fvec_o[0], 0);

        sweep(3, 20);
        chk("vec2_fail_fvec", fvec_o[1], 2);

        // Abort sampled at the end of cycle 4.
        step(1'b1, 1'b0, 2);
        for (int c = 1; c <= 4; c++) step(1'b0, c == 4, 2);
        @(negedge clk);
        chk("abort_busy", busy_o[0], 0);
        chk("abort_vec", vec_o[0], 0);
        chk("abort_err_hold", err_o[0], 1);
        step(1'b0, 1'b0, 0);
        sweep(0, 20);
        chk("rerun_err", err_o[0], 0);
        chk("rerun_pass", pass_o[0], 1);

        // Reset mid-sweep, then a clean sweep.
        step(1'b1, 1'b0, 2);
        for (int c = 1; c <= 5; c++) step(1'b0, 1'b0, 2);
        mid_reset();
        sweep(0, 20);
        chk("post_rst_pass", pass_o[1], 1);

        for (int n = 0; n < 4000; n++) begin
            int md;
            md = mode;
            if ($urandom_range(0, 15) == 0) md = $urandom_range(0, 3);
            if ($urandom_range(0, 600) == 0) mid_reset();
            else step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, md);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/demorgan_sweep_ctrl.md
Name: demorgan_sweep_ctrl

Overview:
Sequencer and self-checker for the two-input De Morgan gate datapath. It steps the gate inputs through every input combination in ascending binary order and waits a programmable settle time for each one. It then compares the gate's NAND-form and NOR-form outputs against internally computed expected values. Pass/fail, the error count and the first failing vector are reported. It replaces hand-stepped stimulus with a clocked, repeatable sweep usable in-system and on the bench.

Parameters:
N_IN, 2, number of datapath inputs driven; legal 1..8.
SETTLE, 1, cycles the inputs are held before sampling; legal 1..255.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin sweep; sampled only in IDLE.
abort  input  1  synchronous abort; returns to IDLE.
vec_out  output  N_IN  drive vector to datapath inputs (bit0 = B, bit1 = A when N_IN=2).
dut_nand  input  1  datapath output that must equal ~(&vec_out), i.e. ~A|~B.
dut_nor  input  1  datapath output that must equal ~(|vec_out), i.e. ~A&~B.
busy  output  1  high in WAIT/CHECK.
done  output  1  one-cycle pulse at sweep completion.
pass  output  1  high after completion if err_count==0; held until next start.
err_count  output  N_IN+1  number of vectors with any mismatch.
fail_vec  output  N_IN  first mismatching vector.
fail_seen  output  1  fail_vec is valid.

Behaviour:
- Reset (async, rst_n=0): state IDLE; vec_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_seen=0, settle counter=0.
- States and transitions:
  - IDLE: on start=1, go to WAIT. Load vec_out=0 and settle counter=SETTLE. Clear err_count, pass, fail_seen and fail_vec.
  - WAIT: decrement the counter each cycle. On the cycle the counter reaches 1, go to CHECK. WAIT therefore lasts exactly SETTLE cycles.
  - CHECK: one cycle. Mismatch = (dut_nand != ~&vec_out) | (dut_nor != ~|vec_out).
    - On mismatch: err_count+1. If fail_seen=0, capture fail_vec=vec_out and set fail_seen=1.
    - If vec_out is all ones, go to DONE.
    - Otherwise vec_out+1, reload the counter, go to WAIT.
  - DONE: done=1 for this cycle only. Set pass=(final err_count==0), then go to IDLE.
- vec_out changes only on the IDLE->WAIT or CHECK->WAIT edge. It is stable through every WAIT and CHECK cycle and holds its last value in IDLE/DONE.
- Timing: with start sampled at cycle 0, CHECK for vector k occurs at cycle (k+1)*(SETTLE+1). done is high at cycle 2^N_IN*(SETTLE+1)+1. For N_IN=2, SETTLE=1, done is at cycle 9.
- busy=1 exactly in WAIT and CHECK.
- start while busy or in DONE is ignored; there is no queuing.
- abort=1 in WAIT/CHECK/DONE takes priority over every other transition:
  - Next state IDLE; vec_out=0; no done pulse; pass=0.
  - err_count, fail_vec and fail_seen hold their partial values.
- abort and start together in IDLE: abort wins and the sweep does not start.
- err_count never wraps; its maximum is 2^N_IN, which fits in N_IN+1 bits.
- Expected values use all N_IN bits (N-input NAND/NOR). The inputs from the gate are assumed stable once settled; they are not synchronized.
- Asserting rst_n mid-sweep clears everything immediately; no done pulse.

Test Plan:
- Correct gate model, N_IN=2, SETTLE=1; start pulse at cycle 0 -> vec_out runs 00,01,10,11, each held 2 cycles; done at cycle 9; pass=1, err_count=0, fail_seen=0.
- Gate model with dut_nor stuck at 0 -> mismatch only at vec 00; err_count=1, fail_vec=00, fail_seen=1, pass=0.
- Gate model with dut_nand inverted -> all 4 vectors fail; err_count=4 (no wrap), fail_vec=00.
- SETTLE=3; start -> each vector held 4 cycles; done at cycle 17; a start pulse at cycle 5 is ignored with no timing change.
- abort at cycle 4 -> next cycle IDLE, vec_out=00, busy=0, no done, err_count holds. A subsequent start then re-runs cleanly with err_count cleared.
- rst_n low at cycle 6 mid-sweep -> all outputs 0 asynchronously (before the next edge). After release, start gives the nominal sweep.
